// File: rtl/next_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : next_pc_unit                                              |
// | Purpose  : Program counter / next-PC stage for the MIPS-lite core.   |
// |            Fetches over a req/ack handshake, latches the word,       |
// |            raises a one-cycle execute strobe, then resolves the      |
// |            branch/jump select and loads the new PC. Holds a sticky   |
// |            zero-status flag (bz) and a sticky fetch-timeout fault.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |  clk, reset             clock, synchronous active-high reset         |
// |  imem_addr/req/ack/rdata instruction memory fetch handshake          |
// |  instr, exec_valid      latched instruction and execute strobe       |
// |  bj, alu_zero, rs_sign  branch/jump select and conditions (EXEC)     |
// |  status_we, result_zero zero-status flag update (EXEC)               |
// |  pc, link_pc, taken     current PC, PC+4, redirect indicator         |
// |  fault                  sticky fetch-timeout flag                    |
// +----------------------------------------------------------------------+
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        exec_valid,
  input  logic [2:0]  bj,
  input  logic        alu_zero,
  input  logic        rs_sign,
  input  logic        status_we,
  input  logic        result_zero,
  output logic [31:0] pc,
  output logic [31:0] link_pc,
  output logic        taken,
  output logic        fault
);

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            zflag_q, zflag_d;
  logic            fault_q, fault_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [31:0]     p4;
  logic [31:0]     boff;
  logic [31:0]     jt;
  logic            redirect;
  logic [31:0]     target;

  // Target candidates, all relative to the instruction currently held.
  assign p4   = pc_q + 32'd4;
  assign boff = p4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jt   = {p4[31:28], instr_q[25:0], 2'b00};

  // Redirect decision; bz reads the flag value from before this EXEC's update.
  always_comb begin
    redirect = 1'b0;
    target   = jt;
    case (bj)
      3'b110: begin redirect = alu_zero; target = boff; end
      3'b101: begin redirect = rs_sign;  target = boff; end
      3'b001: redirect = zflag_q;
      3'b011: redirect = 1'b1;
      3'b010: redirect = 1'b1;
      default: redirect = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    zflag_d = zflag_q;
    fault_d = fault_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          timer_d = '0;
          state_d = ST_EXEC;
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_EXEC: begin
        pc_d    = redirect ? target : p4;
        if (status_we) zflag_d = result_zero;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      zflag_q <= 1'b0;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      zflag_q <= zflag_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign exec_valid = (state_q == ST_EXEC);
  assign taken      = exec_valid & redirect;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign link_pc    = p4;
  assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_next_pc_unit                                           |
// | Purpose  : Scoreboard bench for next_pc_unit. The driver issues      |
// |            fetch responses and EXEC-cycle controls and queues the    |
// |            hand-computed outcome; a monitor compares on exec_valid.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_next_pc_unit;

  localparam logic [31:0] R = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        exec_valid;
  logic [2:0]  bj;
  logic        alu_zero, rs_sign, status_we, result_zero;
  logic [31:0] pc, link_pc;
  logic        taken, fault;

  // Second instance only to observe PC+4 wrap at the top of the address space.
  logic [31:0] w_addr, w_instr, w_pc, w_link;
  logic        w_req, w_exec, w_taken, w_fault;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic [2:0]  w_zero3 = 3'b000;

  always #5 clk = ~clk;

  next_pc_unit #(.RESET_PC(R), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .exec_valid(exec_valid),
    .bj(bj), .alu_zero(alu_zero), .rs_sign(rs_sign),
    .status_we(status_we), .result_zero(result_zero),
    .pc(pc), .link_pc(link_pc), .taken(taken), .fault(fault)
  );

  next_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(2)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_addr(w_addr), .imem_req(w_req), .imem_ack(w_zero),
    .imem_rdata(w_zero32), .instr(w_instr), .exec_valid(w_exec),
    .bj(w_zero3), .alu_zero(w_zero), .rs_sign(w_zero),
    .status_we(w_zero), .result_zero(w_zero),
    .pc(w_pc), .link_pc(w_link), .taken(w_taken), .fault(w_fault)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] link;
    logic [31:0] next;
    logic        taken;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares every execute strobe against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exec_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_exec", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("exec_instr", instr, e.instr);
          check("exec_taken", {31'b0, taken}, {31'b0, e.taken});
          check("exec_link",  link_pc, e.link);
          @(posedge clk); #1;
          check("next_pc", pc, e.next);
          check("exec_one_cycle", {31'b0, exec_valid}, 32'd0);
        end
      end
    end
  end

  // Issue one instruction: wait for req, hold off ack for 'dly' cycles,
  // return 'rdata', and drive the EXEC controls around the EXEC cycle.
  task automatic issue(input logic [31:0] rdata, input int dly, input logic [2:0] bj_v,
                       input logic az, input logic rs, input logic swe, input logic rz,
                       input logic exp_taken, input logic [31:0] cur_pc,
                       input logic [31:0] exp_next, input bit rst_in_exec);
    exp_t e;
    int   n = 0;
    while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("req_wait_timeout", 32'd1, 32'd0);
    repeat (dly) @(negedge clk);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, cur_pc);
    e.instr = rdata; e.link = cur_pc + 32'd4; e.next = exp_next; e.taken = exp_taken;
    exp_q.push_back(e);
    imem_ack = 1'b1; imem_rdata = rdata;
    bj = bj_v; alu_zero = az; rs_sign = rs; status_we = swe; result_zero = rz;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    if (rst_in_exec) reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bj = 3'b000; alu_zero = 1'b0; rs_sign = 1'b0; status_we = 1'b0; result_zero = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] frozen;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    bj = 3'b000; alu_zero = 1'b0; rs_sign = 1'b0; status_we = 1'b0; result_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, R);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_exec", {31'b0, exec_valid}, 32'd0);
    check("rst_taken", {31'b0, taken}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_link", link_pc, R + 32'd4);
    check("wrap_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_link", w_link, 32'h0000_0000);
    reset = 1'b0;

    //     rdata          dly bj      az    rs    swe   rz    tk    pc             next
    issue(32'h0000_0000, 2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, R,             R + 32'd4,     0);
    issue(32'h0800_0004, 0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R + 32'd4,     32'h3000_0010, 0);
    issue(32'h0800_0040, 0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0010, 32'h3000_0100, 0);
    issue(32'h1000_FFFF, 1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0100, 32'h3000_0100, 0);
    issue(32'h1000_FFFF, 0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3000_0100, 32'h3000_0104, 0);
    issue(32'h0400_0010, 0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3000_0104, 32'h3000_0148, 0);
    issue(32'h0400_0010, 0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3000_0148, 32'h3000_014C, 0);
    issue(32'h0000_0080, 0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000_014C, 32'h3000_0150, 0);
    issue(32'h0000_0080, 15,3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0150, 32'h3000_0200, 0);
    issue(32'h0C00_00C0, 0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0200, 32'h3000_0300, 0);
    issue(32'h0000_FFFF, 0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0300, 32'h3000_0304, 0);
    issue(32'h03FF_FFFF, 0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0304, 32'h3000_0308, 0);
    issue(32'h1000_0008, 0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3000_0308, 32'h3000_030C, 0);
    issue(32'h0000_0080, 0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3000_030C, 32'h3000_0310, 0);
    issue(32'h0000_0000, 0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000_0310, 32'h3000_0314, 0);
    issue(32'h1000_FFFF, 0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0314, R,             1);
    issue(32'h0000_0080, 0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, R,             R + 32'd4,     0);

    // Fetch timeout: 16 request cycles without ack, then HALT with fault.
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("req_wait_timeout", 32'd1, 32'd0);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      ok &= (imem_req === 1'b1) && (fault === 1'b0);
    end
    check("timeout_req_held", {31'b0, ok}, 32'd1);
    @(negedge clk);
    check("timeout_fault", {31'b0, fault}, 32'd1);
    check("timeout_req_drop", {31'b0, imem_req}, 32'd0);
    frozen = pc;
    check("halt_pc", frozen, R + 32'd4);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0004; bj = 3'b010;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ok &= (exec_valid === 1'b0) && (imem_req === 1'b0);
    end
    imem_ack = 1'b0; bj = 3'b000;
    check("halt_ack_ignored", {31'b0, ok}, 32'd1);
    check("halt_pc_frozen", pc, R + 32'd4);
    check("halt_fault_sticky", {31'b0, fault}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_clears_fault", {31'b0, fault}, 32'd0);
    check("rst_reload_pc", pc, R);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
